// File: rtl/regfile_wb_arbiter_if.sv
// Bundle for regfile_wb_arbiter: two producer handshakes, the register-file
// write port, and the two forwarding lookups.
interface regfile_wb_arbiter_if #(
   parameter int DW = 32
);
   logic          i_a_valid;
   logic          o_a_ready;
   logic [4:0]    i_a_wad;
   logic [DW-1:0] i_a_wdata;
   logic          i_b_valid;
   logic          o_b_ready;
   logic [4:0]    i_b_wad;
   logic [DW-1:0] i_b_wdata;
   logic          o_we;
   logic [4:0]    o_wad;
   logic [DW-1:0] o_wdata;
   logic [4:0]    i_rada;
   logic [4:0]    i_radb;
   logic          o_fwda_hit;
   logic          o_fwdb_hit;
   logic [DW-1:0] o_fwda_data;
   logic [DW-1:0] o_fwdb_data;
   logic          o_busy;

   modport slave (
      input  i_a_valid, i_a_wad, i_a_wdata,
      input  i_b_valid, i_b_wad, i_b_wdata,
      input  i_rada, i_radb,
      output o_a_ready, o_b_ready,
      output o_we, o_wad, o_wdata,
      output o_fwda_hit, o_fwdb_hit, o_fwda_data, o_fwdb_data,
      output o_busy
   );

   modport master (
      output i_a_valid, i_a_wad, i_a_wdata,
      output i_b_valid, i_b_wad, i_b_wdata,
      output i_rada, i_radb,
      input  o_a_ready, o_b_ready,
      input  o_we, o_wad, o_wdata,
      input  o_fwda_hit, o_fwdb_hit, o_fwda_data, o_fwdb_data,
      input  o_busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two per-source FIFOs feeding one register-file write port.
// Define REGFILE_WB_FWD_EN to enable forwarding lookups over queued results.
module regfile_wb_arbiter #(
   parameter int DW     = 32,
   parameter int DEPTH  = 2,
   parameter int STARVE = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE + 1);

   typedef struct packed {
      logic [4:0]    wad;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mem_a_q [DEPTH];
   ent_t          mem_b_q [DEPTH];
   logic [AW-1:0] wr_a_q, rd_a_q, wr_b_q, rd_b_q;
   logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          we_q;
   logic [4:0]    wad_q;
   logic [DW-1:0] wdata_q;

   logic ready_a, ready_b, push_a, push_b;
   logic a_ne, b_ne, gnt_a, gnt_b;
   ent_t head_a, head_b;

   // A full FIFO refuses input even while it is being popped.
   assign ready_a = (cnt_a_q != CW'(DEPTH)) && rst_n;
   assign ready_b = (cnt_b_q != CW'(DEPTH)) && rst_n;
   assign push_a  = bus.i_a_valid && ready_a && (bus.i_a_wad != 5'd0);
   assign push_b  = bus.i_b_valid && ready_b && (bus.i_b_wad != 5'd0);
   assign a_ne    = (cnt_a_q != '0);
   assign b_ne    = (cnt_b_q != '0);
   assign head_a  = mem_a_q[rd_a_q];
   assign head_b  = mem_b_q[rd_b_q];

   always_comb begin
      gnt_b    = b_ne && (!a_ne || (starve_q == SW'(STARVE)));
      gnt_a    = a_ne && !gnt_b;
      starve_d = starve_q;
      if (!b_ne || gnt_b) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE)) begin
         starve_d = starve_q + SW'(1);
      end
      cnt_a_d = cnt_a_q + CW'(push_a) - CW'(gnt_a);
      cnt_b_d = cnt_b_q + CW'(push_b) - CW'(gnt_b);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_a_q   <= '0;
         rd_a_q   <= '0;
         wr_b_q   <= '0;
         rd_b_q   <= '0;
         cnt_a_q  <= '0;
         cnt_b_q  <= '0;
         starve_q <= '0;
         we_q     <= 1'b0;
         wad_q    <= '0;
         wdata_q  <= '0;
      end else begin
         if (push_a) wr_a_q <= wr_a_q + AW'(1);
         if (push_b) wr_b_q <= wr_b_q + AW'(1);
         if (gnt_a)  rd_a_q <= rd_a_q + AW'(1);
         if (gnt_b)  rd_b_q <= rd_b_q + AW'(1);
         cnt_a_q  <= cnt_a_d;
         cnt_b_q  <= cnt_b_d;
         starve_q <= starve_d;
         we_q     <= gnt_a || gnt_b;
         if (gnt_b) begin
            wad_q   <= head_b.wad;
            wdata_q <= head_b.data;
         end else if (gnt_a) begin
            wad_q   <= head_a.wad;
            wdata_q <= head_a.data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_a) mem_a_q[wr_a_q] <= {bus.i_a_wad, bus.i_a_wdata};
      if (push_b) mem_b_q[wr_b_q] <= {bus.i_b_wad, bus.i_b_wdata};
   end

   assign bus.o_a_ready = ready_a;
   assign bus.o_b_ready = ready_b;
   assign bus.o_we      = we_q;
   assign bus.o_wad     = wad_q;
   assign bus.o_wdata   = wdata_q;
   assign bus.o_busy    = a_ne || b_ne || we_q;

`ifdef REGFILE_WB_FWD_EN
   // Scan oldest to youngest so the youngest match wins; the output register
   // is checked first so any FIFO match overrides it.
   function automatic logic [DW:0] fwd_lookup(input logic [4:0] rad);
      logic [DW:0]   r;
      logic [AW-1:0] idx;
      r = '0;
      if (rad != 5'd0) begin
         if (we_q && (wad_q == rad)) r = {1'b1, wdata_q};
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_a_q + AW'(i);
            if ((i < int'(cnt_a_q)) && (mem_a_q[idx].wad == rad)) r = {1'b1, mem_a_q[idx].data};
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_b_q + AW'(i);
            if ((i < int'(cnt_b_q)) && (mem_b_q[idx].wad == rad)) r = {1'b1, mem_b_q[idx].data};
         end
      end
      return r;
   endfunction

   always_comb begin
      {bus.o_fwda_hit, bus.o_fwda_data} = fwd_lookup(bus.i_rada);
      {bus.o_fwdb_hit, bus.o_fwdb_data} = fwd_lookup(bus.i_radb);
   end
`else
   logic unused_fwd;
   assign unused_fwd      = ^{bus.i_rada, bus.i_radb};
   assign bus.o_fwda_hit  = 1'b0;
   assign bus.o_fwdb_hit  = 1'b0;
   assign bus.o_fwda_data = '0;
   assign bus.o_fwdb_data = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DW=32, DEPTH=2, STARVE=4).
module tb_regfile_wb_arbiter;
   localparam int DW = 32;
`ifdef REGFILE_WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_assert = 0;
   int   n_fail = 0;
   int   ka, jb;

   // Expected values per cycle of the dual-stream run (index = edge number - 1).
   int          t_rdy_a [15] = '{1,1,1,1,1,1,0,1,1,1,1,0,1,1,1};
   int          t_rdy_b [15] = '{1,1,0,0,0,0,1,0,0,0,0,1,1,1,1};
   int          t_wad   [15] = '{0,11,12,13,14,7,15,16,17,18,26,19,20,27,0};
   logic [31:0] t_data  [15] = '{32'h0, 32'hA01, 32'hA02, 32'hA03, 32'hA04, 32'hBEEF,
                                 32'hA05, 32'hA06, 32'hA07, 32'hA08, 32'hB02,
                                 32'hA09, 32'hA0A, 32'hB03, 32'h0};

   regfile_wb_arbiter_if #(.DW(DW)) bus ();

   regfile_wb_arbiter #(.DW(DW), .DEPTH(2), .STARVE(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      bus.i_a_valid = 1'b0;
      bus.i_b_valid = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.i_a_valid = 1'b0;
      bus.i_a_wad   = '0;
      bus.i_a_wdata = '0;
      bus.i_b_valid = 1'b0;
      bus.i_b_wad   = '0;
      bus.i_b_wdata = '0;
      bus.i_rada    = 5'd0;
      bus.i_radb    = 5'd0;
      tick();
      tick();

      // Reset state
      chk("rst_rdy_a", bus.o_a_ready, 0);
      chk("rst_rdy_b", bus.o_b_ready, 0);
      chk("rst_we", bus.o_we, 0);
      chk("rst_wad", bus.o_wad, 0);
      chk("rst_wdata", bus.o_wdata, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_hita", bus.o_fwda_hit, 0);
      chk("rst_hitb", bus.o_fwdb_hit, 0);

      // Single A write x5 = 0x1234
      rst_n         = 1'b1;
      bus.i_a_valid = 1'b1;
      bus.i_a_wad   = 5'd5;
      bus.i_a_wdata = 32'h1234;
      #1;
      chk("rel_rdy_a", bus.o_a_ready, 1);
      chk("rel_rdy_b", bus.o_b_ready, 1);
      tick();
      idle();
      chk("t1_we_e1", bus.o_we, 0);
      chk("t1_busy_e1", bus.o_busy, 1);
      tick();
      chk("t1_we_e2", bus.o_we, 1);
      chk("t1_wad_e2", bus.o_wad, 5);
      chk("t1_wdata_e2", bus.o_wdata, 32'h1234);
      chk("t1_busy_e2", bus.o_busy, 1);
      tick();
      chk("t1_we_e3", bus.o_we, 0);
      chk("t1_busy_e3", bus.o_busy, 0);
      chk("t1_wad_hold", bus.o_wad, 5);

      // Write to x0 is accepted and dropped
      bus.i_a_valid = 1'b1;
      bus.i_a_wad   = 5'd0;
      bus.i_a_wdata = 32'hFFFF;
      #1;
      chk("x0_rdy", bus.o_a_ready, 1);
      tick();
      idle();
      chk("x0_we_e1", bus.o_we, 0);
      chk("x0_busy_e1", bus.o_busy, 0);
      tick();
      chk("x0_we_e2", bus.o_we, 0);
      chk("x0_busy_e2", bus.o_busy, 0);

      // Both sources streaming: B starves for 4 A grants, FIFOs fill, order kept
      ka = 1;
      jb = 1;
      for (int c = 0; c < 15; c++) begin
         bus.i_a_valid = (c < 11);
         bus.i_a_wad   = 5'(10 + ka);
         bus.i_a_wdata = 32'h0A00 + 32'(ka);
         bus.i_b_valid = (c < 11);
         bus.i_b_wad   = (jb == 1) ? 5'd7 : 5'(24 + jb);
         bus.i_b_wdata = (jb == 1) ? 32'hBEEF : 32'h0B00 + 32'(jb);
         #1;
         chk($sformatf("st_rdy_a[%0d]", c), bus.o_a_ready, t_rdy_a[c]);
         chk($sformatf("st_rdy_b[%0d]", c), bus.o_b_ready, t_rdy_b[c]);
         if (c < 11 && t_rdy_a[c] == 1) ka++;
         if (c < 11 && t_rdy_b[c] == 1) jb++;
         tick();
         chk($sformatf("st_we[%0d]", c), bus.o_we, (t_wad[c] != 0) ? 1 : 0);
         if (t_wad[c] != 0) begin
            chk($sformatf("st_wad[%0d]", c), bus.o_wad, t_wad[c]);
            chk($sformatf("st_wdata[%0d]", c), bus.o_wdata, t_data[c]);
         end
      end
      idle();
      chk("st_busy_end", bus.o_busy, 0);

      // Forwarding: A x3,x4 and B x9=1,x9=2 queued
      bus.i_a_valid = 1'b1;
      bus.i_a_wad   = 5'd3;
      bus.i_a_wdata = 32'h33;
      bus.i_b_valid = 1'b1;
      bus.i_b_wad   = 5'd9;
      bus.i_b_wdata = 32'd1;
      tick();
      bus.i_a_wad   = 5'd4;
      bus.i_a_wdata = 32'h44;
      bus.i_b_wdata = 32'd2;
      tick();
      idle();
      chk("fw_we", bus.o_we, 1);
      chk("fw_wad", bus.o_wad, 3);
      bus.i_rada = 5'd9;
      bus.i_radb = 5'd0;
      #1;
      chk("fw_hita_x9", bus.o_fwda_hit, FWD ? 1 : 0);
      chk("fw_data_x9", bus.o_fwda_data, FWD ? 2 : 0);
      chk("fw_hitb_x0", bus.o_fwdb_hit, 0);
      bus.i_rada = 5'd4;
      bus.i_radb = 5'd3;
      #1;
      chk("fw_hita_x4", bus.o_fwda_hit, FWD ? 1 : 0);
      chk("fw_data_x4", bus.o_fwda_data, FWD ? 32'h44 : 0);
      chk("fw_hitb_x3", bus.o_fwdb_hit, FWD ? 1 : 0);
      chk("fw_datb_x3", bus.o_fwdb_data, FWD ? 32'h33 : 0);
      chk("fw_busy", bus.o_busy, 1);

      // Reset with both FIFOs holding entries
      bus.i_rada = 5'd9;
      rst_n      = 1'b0;
      #1;
      chk("mr_rdy_a", bus.o_a_ready, 0);
      chk("mr_rdy_b", bus.o_b_ready, 0);
      tick();
      chk("mr_we", bus.o_we, 0);
      chk("mr_wad", bus.o_wad, 0);
      chk("mr_wdata", bus.o_wdata, 0);
      chk("mr_busy", bus.o_busy, 0);
      chk("mr_hita", bus.o_fwda_hit, 0);
      rst_n = 1'b1;
      #1;
      chk("mr_rel_rdy_a", bus.o_a_ready, 1);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("mr_post_we[%0d]", c), bus.o_we, 0);
         chk($sformatf("mr_post_busy[%0d]", c), bus.o_busy, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
